accel_job_sequencer: RTL and testbench

Wishbone master that drives one complete job through the matrix accelerator's register window. It writes the header, streams operands A and B from an upstream valid/ready source, and fires the go word. It then polls for completion and reads the N×N result back out as a valid/ready stream. It sits directly upstream of the accelerator's Wishbone slave port and replaces firmware-driven loading.

---
 rtl/accel_job_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_accel_job_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_sequencer.sv
// accel_job_sequencer
//
// Wishbone master that runs one complete job through the matrix
// accelerator's register window. It writes the job header, streams operands
// A and B from an upstream valid/ready source, writes the go word, polls the
// status word until the accelerator reports completion, and then reads the
// N x N result out as a valid/ready stream.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   start_i, op_i                start request (IDLE only) and op code
//   in_valid_i/in_ready_o/in_data_i     operand stream (A then B, row-major)
//   out_valid_o/out_ready_i/out_data_o/out_last_o  result stream, row-major
//   busy_o, done_o, err_o        job status (done is a 1-cycle pulse,
//                                err is a sticky timeout flag)
//   wbm_*                        single-beat Wishbone master port
//
// Every output comes straight from a register. After each ack the strobe is
// held low for one cycle because the slave ignores a strobe in the cycle
// after its ack.
module accel_job_sequencer #(
  parameter logic [31:0] ADDR_OFFSET    = 32'h3010_0000,
  parameter int          MEM_SIZE       = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [31:0] op_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i
);

  localparam int NN    = MEM_SIZE * MEM_SIZE;
  localparam int IDX_W = $clog2(2 * NN + 1) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] HDR_LAST  = IDX_W'(4);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(2 * NN - 1);
  localparam logic [IDX_W-1:0] RES_LAST  = IDX_W'(NN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [31:0] WORD_GO    = 32'd5;
  localparam logic [31:0] WORD_DATA  = 32'd6;
  localparam logic [31:0] WORD_RES   = 32'(NN / 4);
  localparam logic [31:0] GO_VALUE   = 32'hFFFF_FFFF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_HDR  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_WR_GO   = 3'd3;
  localparam logic [2:0] S_POLL    = 3'd4;
  localparam logic [2:0] S_RD_RES  = 3'd5;
  localparam logic [2:0] S_OUT     = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  function automatic logic [31:0] word_addr(input logic [31:0] word);
    return ADDR_OFFSET + (word << 2);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             stb_q, stb_d;
  logic             gap_q, gap_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      op_q, op_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_seen;
  logic             tmo_hit;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    stb_d       = stb_q;
    gap_d       = 1'b0;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    ack_seen = stb_q & wbm_ack_i;
    tmo_hit  = stb_q & ~wbm_ack_i & (tmo_q == TMO_LAST);

    // Bus cycle bookkeeping: an ack ends the beat and opens the gap cycle.
    if (stb_q) begin
      if (wbm_ack_i) begin
        stb_d = 1'b0;
        gap_d = 1'b1;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // New strobes are only launched while stb is low, which is never the
    // ack cycle itself, so the gap cycle is always preserved.
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_WR_HDR;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = word_addr(32'd0);
          dat_d   = op_i;
        end
      end
      S_WR_HDR: begin
        if (ack_seen) begin
          if (idx_q == HDR_LAST) begin
            idx_d   = '0;
            state_d = S_WR_DATA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = word_addr(32'(idx_q));
          dat_d = (idx_q == '0) ? op_q : 32'(MEM_SIZE);
        end
      end
      S_WR_DATA: begin
        if (ack_seen) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = S_WR_GO;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (in_ready_q && in_valid_i) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = word_addr(WORD_DATA + 32'(idx_q));
          dat_d = in_data_i;
        end
      end
      S_WR_GO: begin
        if (ack_seen) begin
          state_d = S_POLL;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = word_addr(WORD_GO);
          dat_d = GO_VALUE;
        end
      end
      S_POLL: begin
        // A non-zero status just falls through to another poll after the gap.
        if (ack_seen) begin
          if (wbm_dat_i == '0) begin
            idx_d   = '0;
            state_d = S_RD_RES;
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = word_addr(WORD_GO);
        end
      end
      S_RD_RES: begin
        if (ack_seen) begin
          out_data_d  = wbm_dat_i;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == RES_LAST);
          state_d     = S_OUT;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = word_addr(WORD_RES + 32'(idx_q));
        end
      end
      S_OUT: begin
        // The next read is issued in the handshake cycle itself so its
        // strobe lands one cycle after the consumer takes the word.
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == RES_LAST) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_RES;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = word_addr(WORD_RES + 32'(idx_q) + 32'd1);
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A stuck strobe abandons the job from any state.
    if (tmo_hit) begin
      stb_d       = 1'b0;
      gap_d       = 1'b0;
      tmo_d       = '0;
      err_d       = 1'b1;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      state_d     = S_IDLE;
    end

    in_ready_d = (state_d == S_WR_DATA) && !stb_d && !gap_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      stb_q       <= 1'b0;
      gap_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      op_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      stb_q       <= stb_d;
      gap_q       <= gap_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_we_o    = we_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_cyc_o   = stb_q;

  // gap_q only shapes in_ready; keep it referenced for readability of traces.
  logic unused_gap;
  assign unused_gap = gap_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
module tb_accel_job_sequencer;
  localparam int N   = 2;
  localparam int NN  = N * N;
  localparam int TMO = 16;
  localparam logic [31:0] BASE = 32'h3010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] op_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        busy_o, done_o, err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic        wbm_ack_i = 1'b0;

  always #5 clk = ~clk;

  accel_job_sequencer #(
    .ADDR_OFFSET(BASE), .MEM_SIZE(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .op_i(op_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accelerator slave model: register window, matrix multiply, status word.
  logic [31:0] mem [0:63];
  logic [31:0] res [0:NN-1];
  bit          running = 0;
  int          run_cnt = 0;
  int          post_polls = 0;
  int          wait_cnt = 0;
  bit          rand_lat = 0;
  bit          hang_poll = 0;
  int unsigned sw;
  logic [31:0] acc;
  logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
  int unsigned wr_cyc_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      running = 0; run_cnt = 0; post_polls = 0; wait_cnt = 0;
    end else begin
      wbm_ack_i <= 1'b0;
      if (running) begin
        if (run_cnt > 0) run_cnt--;
        else begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              acc = 0;
              for (int k = 0; k < N; k++) acc = acc + mem[6+i*N+k] * mem[6+NN+k*N+j];
              res[i*N+j] = acc;
            end
          running = 0;
          post_polls = 1;
        end
      end
      if (wbm_stb_o && !wbm_ack_i) begin
        sw = (wbm_adr_o - BASE) >> 2;
        if (!wbm_we_o && sw == 5 && (running || hang_poll)) begin
          // status read withheld while the job runs
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          wbm_ack_i <= 1'b1;
          wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
          if (wbm_we_o) begin
            if (sw < 64) mem[sw] = wbm_dat_o;
            wr_adr_q.push_back(wbm_adr_o); wr_dat_q.push_back(wbm_dat_o); wr_cyc_q.push_back(cyc);
            if (sw == 5 && wbm_dat_o == 32'hFFFF_FFFF) begin
              running = 1; run_cnt = int'($urandom_range(2, 6));
            end
          end else begin
            rd_adr_q.push_back(wbm_adr_o);
            if (sw == 5) begin
              wbm_dat_i <= (post_polls > 0) ? 32'd1 : 32'd0;
              if (post_polls > 0) post_polls--;
            end else if (sw >= NN/4 && sw < NN/4 + NN) wbm_dat_i <= res[sw - NN/4];
            else wbm_dat_i <= (sw < 64) ? mem[sw] : 32'd0;
          end
        end
      end
    end
  end

  // Negedge monitors
  logic [31:0] out_q[$];
  bit          last_q[$];
  int done_cnt = 0, gap_viol = 0, cyc_viol = 0, poll_hi = 0, ov_cnt = 0;
  bit prev_ack = 0;
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (out_valid_o) ov_cnt++;
    if (out_valid_o && out_ready_i) begin out_q.push_back(out_data_o); last_q.push_back(out_last_o); end
    if (prev_ack && wbm_stb_o) gap_viol++;
    if (wbm_cyc_o !== wbm_stb_o) cyc_viol++;
    if (wbm_stb_o && !wbm_we_o && wbm_adr_o == BASE + 32'd20) poll_hi++;
    prev_ack = wbm_stb_o && wbm_ack_i;
  end

  logic [31:0] ops_arr [0:2*NN-1];

  task automatic run_job(input logic [31:0] op, input int in_mode, input int out_mode,
                         input bit busy_start, input bit expect_abort);
    int idx, guard, d0, p0, ov0, n_before, r;
    bit hs, lastw, stalled;
    logic [31:0] hold, e_adr, e_dat, c;
    wr_adr_q.delete(); wr_dat_q.delete(); rd_adr_q.delete(); wr_cyc_q.delete();
    out_q.delete(); last_q.delete();
    d0 = done_cnt; p0 = poll_hi; ov0 = ov_cnt;
    start_i = 1'b1; op_i = op;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = $urandom;
    total++;
    if (!(wbm_stb_o === 1'b1 && wbm_we_o === 1'b1 && wbm_adr_o === BASE && wbm_dat_o === op &&
          busy_o === 1'b1 && err_o === 1'b0)) begin
      bad++;
      $display("FAIL first_strobe stb=%b adr=%h dat=%h busy=%b err=%b required stb=1 adr=%h dat=%h busy=1 err=0",
               wbm_stb_o, wbm_adr_o, wbm_dat_o, busy_o, err_o, BASE, op);
    end
    idx = 0; guard = 0;
    while (idx < 2*NN && guard < 2000) begin
      if (busy_start && guard < 4) begin start_i = 1'b1; op_i = ~op; end
      else start_i = 1'b0;
      case (in_mode)
        0: in_valid_i = 1'b1;
        1: in_valid_i = (guard % 2 == 0);
        default: in_valid_i = 1'($urandom_range(0, 1));
      endcase
      in_data_i = ops_arr[idx];
      @(negedge clk);
      hs = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      if (hs) begin
        e_adr = BASE + 32'(24 + 4*idx);
        total++;
        if (!(wbm_stb_o === 1'b1 && wbm_we_o === 1'b1 && wbm_adr_o === e_adr && wbm_dat_o === ops_arr[idx])) begin
          bad++;
          $display("FAIL operand_write[%0d] stb=%b adr=%h dat=%h required stb=1 adr=%h dat=%h",
                   idx, wbm_stb_o, wbm_adr_o, wbm_dat_o, e_adr, ops_arr[idx]);
        end
        idx++;
      end
      guard++;
    end
    in_valid_i = 1'b0; start_i = 1'b0;
    total++;
    if (idx != 2*NN) begin bad++; $display("FAIL operand_accept got=%0d required=%0d", idx, 2*NN); end

    guard = 0; stalled = 0;
    while (done_cnt == d0 && guard < 3000) begin
      if (out_mode == 1 && !stalled && out_q.size() == 2 && out_valid_o) begin
        out_ready_i = 1'b0; hold = out_data_o;
        repeat (10) begin
          @(negedge clk);
          total++;
          if (out_data_o !== hold || out_valid_o !== 1'b1 || wbm_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL out_stall data=%h valid=%b stb=%b required data=%h valid=1 stb=0",
                     out_data_o, out_valid_o, wbm_stb_o, hold);
          end
          @(posedge clk); #1;
        end
        stalled = 1;
      end
      out_ready_i = (out_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      n_before = out_q.size();
      @(negedge clk);
      hs = out_valid_o && out_ready_i; lastw = out_last_o;
      @(posedge clk); #1;
      if (hs && !lastw) begin
        e_adr = BASE + 32'(4 * (NN/4 + n_before + 1));
        total++;
        if (!(wbm_stb_o === 1'b1 && wbm_we_o === 1'b0 && wbm_adr_o === e_adr)) begin
          bad++;
          $display("FAIL next_read stb=%b we=%b adr=%h required stb=1 we=0 adr=%h", wbm_stb_o, wbm_we_o, wbm_adr_o, e_adr);
        end
      end
      guard++;
    end
    out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_pulses got=%0d required=1", done_cnt - d0); end
    total++;
    if (busy_o !== 1'b0 || err_o !== expect_abort) begin
      bad++; $display("FAIL end_status busy=%b err=%b required busy=0 err=%b", busy_o, err_o, expect_abort);
    end
    total++;
    if (gap_viol != 0 || cyc_viol != 0) begin
      bad++; $display("FAIL bus_protocol gap_viol=%0d cyc_viol=%0d required 0 0", gap_viol, cyc_viol);
    end
    // Expected write sequence: header, operands, go word.
    total++;
    if (wr_adr_q.size() != 6 + 2*NN - (expect_abort ? 0 : 0)) begin
      bad++; $display("FAIL write_count got=%0d required=%0d", wr_adr_q.size(), 6 + 2*NN);
    end
    for (int i = 0; i < 6 + 2*NN && i < wr_adr_q.size(); i++) begin
      if (i < 5) begin e_adr = BASE + 32'(4*i); e_dat = (i == 0) ? op : 32'(N); end
      else if (i < 5 + 2*NN) begin e_adr = BASE + 32'(24 + 4*(i-5)); e_dat = ops_arr[i-5]; end
      else begin e_adr = BASE + 32'd20; e_dat = 32'hFFFF_FFFF; end
      total++;
      if (wr_adr_q[i] !== e_adr || wr_dat_q[i] !== e_dat) begin
        bad++; $display("FAIL write[%0d] adr=%h dat=%h required adr=%h dat=%h", i, wr_adr_q[i], wr_dat_q[i], e_adr, e_dat);
      end
    end
    if (expect_abort) begin
      total++;
      if (poll_hi - p0 != TMO) begin bad++; $display("FAIL timeout_strobe_cycles got=%0d required=%0d", poll_hi - p0, TMO); end
      total++;
      if (ov_cnt != ov0 || out_q.size() != 0) begin
        bad++; $display("FAIL abort_no_output valid_cycles=%0d words=%0d required 0 0", ov_cnt - ov0, out_q.size());
      end
    end else begin
      total++;
      if (out_q.size() != NN) begin bad++; $display("FAIL result_count got=%0d required=%0d", out_q.size(), NN); end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          c = 0;
          for (int k = 0; k < N; k++) c = c + ops_arr[i*N+k] * ops_arr[NN+k*N+j];
          if (i*N+j < out_q.size()) begin
            total++;
            if (out_q[i*N+j] !== c || last_q[i*N+j] !== (i*N+j == NN-1)) begin
              bad++; $display("FAIL result[%0d] data=%h last=%b required data=%h last=%b",
                              i*N+j, out_q[i*N+j], last_q[i*N+j], c, (i*N+j == NN-1));
            end
          end
        end
      r = 0;
      foreach (rd_adr_q[i]) begin
        if (rd_adr_q[i] != BASE + 32'd20) begin
          total++;
          if (rd_adr_q[i] !== BASE + 32'(4*(NN/4 + r))) begin
            bad++; $display("FAIL result_read[%0d] adr=%h required=%h", r, rd_adr_q[i], BASE + 32'(4*(NN/4 + r)));
          end
          r++;
        end
      end
      total++;
      if (rd_adr_q.size() - r != 2) begin bad++; $display("FAIL poll_reads got=%0d required=2", rd_adr_q.size() - r); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, err_o,
         wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o} !== 105'd0) begin
      bad++; $display("FAIL reset_outputs adr=%h dat=%h out=%h stb=%b busy=%b required all zero",
                      wbm_adr_o, wbm_dat_o, out_data_o, wbm_stb_o, busy_o);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset ready=%b busy=%b stb=%b required 0 0 0", in_ready_o, busy_o, wbm_stb_o);
    end
  endtask

  task automatic test_header_job();
    rand_lat = 0;
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = 32'(i + 1);
    run_job(32'd1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_cyc_q[i+1] - wr_cyc_q[i] != 3) begin
        bad++; $display("FAIL header_spacing[%0d] got=%0d required=3", i, wr_cyc_q[i+1] - wr_cyc_q[i]);
      end
    end
    total++;
    if (out_q.size() != 4 || out_q[0] !== 32'd19 || out_q[1] !== 32'd22 || out_q[2] !== 32'd43 || out_q[3] !== 32'd50) begin
      bad++; $display("FAIL known_result got %0d words required 19,22,43,50", out_q.size());
    end
  endtask

  task automatic test_backpressure();
    rand_lat = 1;
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom;
    run_job($urandom, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random_jobs();
    rand_lat = 1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom_range(0, 1000);
      run_job($urandom, 2, 2, 1'b0, 1'b0);
    end
  endtask

  task automatic test_busy_start();
    int n;
    rand_lat = 1;
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom;
    run_job(32'hA5A5_0001, 0, 0, 1'b1, 1'b0);
    n = wr_adr_q.size();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (wr_adr_q.size() != n || busy_o !== 1'b0) begin
      bad++; $display("FAIL busy_start_ignored writes=%0d busy=%b required writes=%0d busy=0", wr_adr_q.size(), busy_o, n);
    end
  endtask

  task automatic test_timeout();
    rand_lat = 1; hang_poll = 1;
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom;
    run_job(32'd7, 0, 0, 1'b0, 1'b1);
    hang_poll = 0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required=1", err_o); end
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom_range(0, 50);
    run_job(32'd8, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int guard;
    rand_lat = 0;
    start_i = 1'b1; op_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1234;
    guard = 0;
    while (!(wbm_stb_o && wbm_adr_o >= BASE + 32'd24) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    total++;
    if (guard >= 200) begin bad++; $display("FAIL reach_wr_data stb=%b adr=%h required data write strobe", wbm_stb_o, wbm_adr_o); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, err_o,
         wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o} !== 105'd0) begin
      bad++; $display("FAIL async_reset_outputs adr=%h dat=%h stb=%b busy=%b required all zero",
                      wbm_adr_o, wbm_dat_o, wbm_stb_o, busy_o);
    end
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_async_reset ready=%b busy=%b stb=%b required 0 0 0", in_ready_o, busy_o, wbm_stb_o);
    end
    for (int i = 0; i < 2*NN; i++) ops_arr[i] = $urandom_range(0, 99);
    run_job(32'd9, 2, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_header_job();
    test_backpressure();
    test_random_jobs();
    test_busy_start();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
